// File: rtl/pixel_writer.sv
// Write stage at the tail of the pixel pipeline. It turns (x, y, pixel) into a linear
// frame-buffer address, queues the writes in a small FIFO and drains them into the RAM.
module pixel_writer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        img_x_in,
    input  logic [9:0]        img_y_in,
    input  logic [7:0]        pixel_in,
    input  logic              mem_busy,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output logic [1:0]        o_dbg_state
);

    localparam int PIX_TOTAL = IMG_W * IMG_H;
    localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int FCNT_W    = $clog2(DEPTH + 1);
    localparam int MUL_W     = ADDR_W + 10;
    localparam int ENTRY_W   = ADDR_W + 8;

    localparam logic [10:0]       X_LIM     = 11'(IMG_W);
    localparam logic [10:0]       Y_LIM     = 11'(IMG_H);
    localparam logic [MUL_W-1:0]  W_MUL     = MUL_W'(IMG_W);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PIX_TOTAL - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Handshake: a pixel moves when in_valid and in_ready are both high at a rising
    // edge; in_ready never depends on in_valid, and is low whenever the FIFO is full,
    // even if an entry leaves in the same cycle.

    state_t              r_state;
    logic [CNT_W-1:0]    r_accept_cnt;
    logic                r_error;
    logic                r_busy;
    logic                r_frame_done;

    logic [ENTRY_W-1:0]  r_fifo [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FCNT_W-1:0]   r_count;

    logic                r_mem_wren;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [7:0]          r_mem_data;

    logic                w_transfer;
    logic                w_in_range;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic [MUL_W-1:0]    w_addr_full;
    logic [ADDR_W-1:0]   w_addr;

    assign in_ready    = (r_state == S_RUN) && (r_count < FIFO_FULL);
    assign w_transfer  = in_valid && in_ready;
    assign w_in_range  = ({1'b0, img_x_in} < X_LIM) && ({1'b0, img_y_in} < Y_LIM);
    assign w_push      = w_transfer && w_in_range;
    assign w_pop       = (r_count != '0) && !mem_busy;
    assign w_last      = w_push && (r_accept_cnt == LAST_CNT);

    // Full-width product; the bounds check keeps the result inside the frame.
    assign w_addr_full = (MUL_W'(img_y_in) * W_MUL) + MUL_W'(img_x_in);
    assign w_addr      = w_addr_full[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_accept_cnt <= '0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_accept_cnt <= '0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_transfer && !w_in_range) begin
                        r_error <= 1'b1;
                    end
                    if (w_push) begin
                        r_accept_cnt <= r_accept_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_count == '0) && !w_pop) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_addr, pixel_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_wren    <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
        end else begin
            r_mem_wren <= w_pop;
            if (w_pop) begin
                {r_mem_address, r_mem_data} <= r_fifo[r_rd_ptr];
            end
        end
    end

    assign mem_wren    = r_mem_wren;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign error       = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: small 4x2 frame instance plus a default-size instance
// for the full-width address computation.
module tb_pixel_writer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [9:0]        img_x = '0;
    logic [9:0]        img_y = '0;
    logic [7:0]        pix = '0;
    logic              mem_busy = 1'b0;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data;
    logic              busy;
    logic              frame_done;
    logic              error;
    logic [1:0]        dbg_state;

    logic              b_start = 1'b0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [9:0]        b_x = '0;
    logic [9:0]        b_y = '0;
    logic [7:0]        b_pix = '0;
    logic              b_mem_busy = 1'b0;
    logic              b_wren;
    logic [16:0]       b_addr;
    logic [7:0]        b_data;
    logic              b_busy;
    logic              b_done;
    logic              b_error;
    logic [1:0]        b_state;

    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_exp;
    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    pixel_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .img_x_in(img_x), .img_y_in(img_y), .pixel_in(pix), .mem_busy(mem_busy),
        .mem_wren(mem_wren), .mem_address(mem_address), .mem_data(mem_data),
        .busy(busy), .frame_done(frame_done), .error(error), .o_dbg_state(dbg_state)
    );

    pixel_writer u_big (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .img_x_in(b_x), .img_y_in(b_y), .pixel_in(b_pix), .mem_busy(b_mem_busy),
        .mem_wren(b_wren), .mem_address(b_addr), .mem_data(b_data),
        .busy(b_busy), .frame_done(b_done), .error(b_error), .o_dbg_state(b_state)
    );

    // Scoreboard: every RAM write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && mem_wren) begin
            n_writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_address, mem_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_address, mem_data} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_address, mem_data, mon_exp[ADDR_W+7:8], mon_exp[7:0]);
                end
            end
        end
        if (!reset && frame_done) n_done++;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL start_response: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
    endtask

    task automatic push_px(input int x, input int y, input logic [7:0] p);
        bit accepted = 1'b0;
        img_x = x[9:0];
        img_y = y[9:0];
        pix = p;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !accepted; t++) begin
            if (in_ready === 1'b1) begin
                accepted = 1'b1;
                if (x < IMG_W && y < IMG_H) exp_q.push_back({ADDR_W'(y * IMG_W + x), p});
            end
            @(negedge clk);
        end
        n_checks++;
        if (!accepted) begin
            n_errors++;
            $display("FAIL push_timeout: got in_ready=0 for 40 cycles, required acceptance of (%0d,%0d)", x, y);
        end
    endtask

    task automatic wait_done(input bit start_in_done);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (frame_done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL frame_done_seen: got no pulse within 20 cycles, required one");
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL after_done: got frame_done=%b busy=%b state=%0d, required 0 0 %0d",
                     frame_done, busy, dbg_state, ST_IDLE);
        end
        @(negedge clk);
        n_checks++;
        if (n_done !== 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse_count: got %0d pulses busy=%b, required 1 pulse busy=0", n_done, busy);
        end
    endtask

    task automatic check_writes(input string name, input int want);
        n_checks++;
        if (n_writes !== want || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL %s: got %0d writes (%0d pending), required %0d writes (0 pending)",
                     name, n_writes, exp_q.size(), want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({in_ready, mem_wren, busy, frame_done, error} !== 5'b0 || mem_address !== '0 ||
            mem_data !== 8'h00 || dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL %s: got rdy=%b wren=%b addr=%0d data=%h busy=%b done=%b err=%b st=%0d, required all 0",
                     name, in_ready, mem_wren, mem_address, mem_data, busy, frame_done, error, dbg_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_reset_mid_frame();
        mem_busy = 1'b1;
        do_start();
        for (int i = 0; i < 3; i++) push_px(i, 0, 8'h60 + 8'(i));
        in_valid = 1'b0;
        n_checks++;
        if (dbg_state !== ST_RUN) begin
            n_errors++;
            $display("FAIL mid_frame_state: got %0d, required %0d", dbg_state, ST_RUN);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_idle_outputs("reset_mid_frame");
        reset = 1'b0;
        mem_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_wren !== 1'b0) begin
                n_errors++;
                $display("FAIL flushed_no_write: got mem_wren=%b, required 0", mem_wren);
            end
        end
    endtask

    task automatic test_raster();
        n_writes = 0;
        n_done = 0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (in_ready !== 1'b1 || mem_wren !== (i >= 2)) begin
                n_errors++;
                $display("FAIL raster_stream[%0d]: got in_ready=%b mem_wren=%b, required 1 %b",
                         i, in_ready, mem_wren, (i >= 2));
            end
            img_x = 10'(i % IMG_W);
            img_y = 10'(i / IMG_W);
            pix = 8'h10 + 8'(i);
            in_valid = 1'b1;
            exp_q.push_back({ADDR_W'(i), 8'h10 + 8'(i)});
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || mem_wren !== 1'b1) begin
            n_errors++;
            $display("FAIL raster_drain: got in_ready=%b busy=%b wren=%b, required 0 1 1", in_ready, busy, mem_wren);
        end
        @(negedge clk);
        n_checks++;
        if (mem_wren !== 1'b1) begin
            n_errors++;
            $display("FAIL raster_last_write: got mem_wren=%b, required 1", mem_wren);
        end
        @(negedge clk);
        wait_done(1'b0);
        check_writes("raster_write_count", 8);
    endtask

    task automatic test_back_pressure();
        logic [7:0] bp_p [8];
        int idx = 0;
        int accepted = 0;
        bit acc_now;
        for (int i = 0; i < 8; i++) bp_p[i] = 8'($urandom_range(0, 255));
        n_writes = 0;
        n_done = 0;
        mem_busy = 1'b1;
        do_start();
        img_x = 10'(idx % IMG_W);
        img_y = 10'(idx / IMG_W);
        pix = bp_p[idx];
        in_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            acc_now = in_ready;
            if (acc_now) begin
                exp_q.push_back({ADDR_W'(idx), bp_p[idx]});
                accepted++;
            end
            @(negedge clk);
            if (acc_now) begin
                idx++;
                img_x = 10'(idx % IMG_W);
                img_y = 10'(idx / IMG_W);
                pix = bp_p[idx];
            end
        end
        n_checks++;
        if (accepted !== DEPTH || in_ready !== 1'b0 || mem_wren !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: got %0d accepted in_ready=%b wren=%b, required %0d 0 0",
                     accepted, in_ready, mem_wren, DEPTH);
        end
        in_valid = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_wren !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_first_pop: got wren=%b in_ready=%b, required 1 1", mem_wren, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_wren !== (i < 3)) begin
                n_errors++;
                $display("FAIL bp_drain[%0d]: got wren=%b, required %b", i, mem_wren, (i < 3));
            end
        end
        for (int i = 4; i < 8; i++) push_px(i % IMG_W, i / IMG_W, bp_p[i]);
        in_valid = 1'b0;
        wait_done(1'b0);
        check_writes("bp_write_count", 8);
    endtask

    task automatic test_out_of_range();
        n_writes = 0;
        n_done = 0;
        do_start();
        push_px(0, 0, 8'h21);
        push_px(1, 0, 8'h22);
        push_px(4, 0, 8'hEE);
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_x_error: got error=%b, required 1", error);
        end
        push_px(0, 2, 8'hEF);
        push_px(2, 0, 8'h23);
        push_px(3, 0, 8'h24);
        push_px(0, 1, 8'h25);
        push_px(1, 1, 8'h26);
        push_px(2, 1, 8'h27);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b1 || dbg_state !== ST_RUN || n_done !== 0) begin
            n_errors++;
            $display("FAIL oor_frame_open: got err=%b busy=%b st=%0d done=%0d, required 1 1 %0d 0",
                     error, busy, dbg_state, n_done, ST_RUN);
        end
        push_px(3, 1, 8'h28);
        in_valid = 1'b0;
        wait_done(1'b0);
        check_writes("oor_write_count", 8);
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_sticky: got error=%b, required 1", error);
        end
    endtask

    task automatic test_address_math();
        n_writes = 0;
        n_done = 0;
        do_start();
        n_checks++;
        if (error !== 1'b0) begin
            n_errors++;
            $display("FAIL error_clear_on_start: got %b, required 0", error);
        end
        push_px(3, 1, 8'hAB);
        in_valid = 1'b0;
        n_checks++;
        if (mem_wren !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got wren=%b one cycle after accept, required 0", mem_wren);
        end
        @(negedge clk);
        n_checks++;
        if (mem_wren !== 1'b1 || mem_address !== 17'd7 || mem_data !== 8'hAB) begin
            n_errors++;
            $display("FAIL addr_3_1: got wren=%b addr=%0d data=%h, required 1 7 ab", mem_wren, mem_address, mem_data);
        end
        for (int i = 0; i < 7; i++) push_px(i % IMG_W, i / IMG_W, 8'h30 + 8'(i));
        in_valid = 1'b0;
        wait_done(1'b0);
        check_writes("addr_write_count", 8);

        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_x = 10'd319;
        b_y = 10'd239;
        b_pix = 8'h5A;
        b_valid = 1'b1;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL big_ready: got %b, required 1", b_ready);
        end
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_wren !== 1'b1 || b_addr !== 17'd76799 || b_data !== 8'h5A) begin
            n_errors++;
            $display("FAIL addr_319_239: got wren=%b addr=%0d data=%h, required 1 76799 5a", b_wren, b_addr, b_data);
        end
    endtask

    task automatic test_ignored_start();
        n_writes = 0;
        n_done = 0;
        do_start();
        for (int i = 0; i < 3; i++) push_px(i, 0, 8'h40 + 8'(i));
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dbg_state !== ST_RUN) begin
            n_errors++;
            $display("FAIL start_in_run: got busy=%b st=%0d, required 1 %0d", busy, dbg_state, ST_RUN);
        end
        for (int i = 3; i < 8; i++) push_px(i % IMG_W, i / IMG_W, 8'h40 + 8'(i));
        in_valid = 1'b0;
        wait_done(1'b1);
        check_writes("ignored_start_writes", 8);
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_raster();
        test_back_pressure();
        test_out_of_range();
        test_address_math();
        test_ignored_start();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Write-side counterpart of the pixel read pipeline. Accepts a stream of processed pixels tagged with destination coordinates, computes the linear frame-buffer address, buffers entries in a small FIFO and drives the destination RAM write port under back-pressure. Sits at the tail of the processing pipeline, after the read stage and pipeline register bank, and signals end of frame to the top-level controller.

## Interface

Parameters:
- IMG_W, 320, destination image width in pixels
- IMG_H, 240, destination image height in pixels
- ADDR_W, 17, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W
- DEPTH, 4, FIFO entries, power of two ≥ 2

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream has a pixel
- in_ready  out  1  block accepts a pixel this cycle
- img_x_in  in  10  destination column
- img_y_in  in  10  destination row
- pixel_in  in  8  pixel value
- mem_busy  in  1  RAM cannot take a write this cycle
- mem_wren  out  1  write strobe, registered
- mem_address  out  ADDR_W  write address, registered
- mem_data  out  8  write data, registered
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse at end of frame
- error  out  1  sticky: an out-of-range coordinate was dropped

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, busy=0. start=1 → RUN; clears accept counter and error.
- RUN: in_ready = (fifo_count < DEPTH); a push when full is never allowed, even if a pop happens the same cycle. Transfer = in_valid & in_ready.
- On transfer: if img_x_in < IMG_W and img_y_in < IMG_H, push {img_y_in*IMG_W + img_x_in truncated to ADDR_W, pixel_in} and increment accept counter; otherwise drop, set error, do not count.
- Accept counter reaches IMG_W*IMG_H (counting the current push) → DRAIN next cycle; in_ready=0 from then on.
- DRAIN: when FIFO empty and no pop pending → DONE.
- DONE: frame_done=1 for exactly one cycle → IDLE.
- Pop: every cycle FIFO is non-empty and mem_busy=0. Popped entry loads mem_address/mem_data and sets mem_wren=1 at the next edge; otherwise mem_wren=0 and address/data hold their last values.
- The address multiply uses full width (ADDR_W+10 bits) before truncation; the bounds check guarantees no overflow.
- start outside IDLE is ignored. Coordinate order is not checked; duplicate addresses are written as given.

## Timing

- Reset (any state, mid-frame included): state=IDLE, FIFO flushed, counters=0. Outputs: in_ready=0, mem_wren=0, mem_address=0, mem_data=0, busy=0, frame_done=0, error=0.
- start at edge N → busy=1 and in_ready=1 after edge N.
- Pixel accepted at edge N → FIFO non-empty after N → with mem_busy=0, mem_wren=1 after edge N+1. Latency is 2 cycles.
- Steady state with mem_busy=0: one write per cycle and in_ready held high.
- mem_busy=1 sampled at edge M → mem_wren=0 after M; entries retained.
- Final write strobe at cycle K → DONE after K, frame_done high for the cycle after K+1, IDLE after that.

## Test plan

Bench parameters: IMG_W=4, IMG_H=2, DEPTH=4.
- Reset mid-frame: start, push 3 pixels, assert reset 1 cycle → all outputs 0, no further mem_wren, state IDLE; a new start behaves normally.
- Raster frame: start, push 8 pixels (x=0..3, y=0..1, pixel=0x10+n) back-to-back, mem_busy=0 → 8 writes at addresses 0..7 with data 0x10..0x17, each 2 cycles after acceptance; one frame_done pulse; busy low afterwards.
- Back-pressure: hold mem_busy=1 and push continuously → exactly 4 accepted, in_ready=0; release mem_busy → 4 writes in order on consecutive cycles, in_ready returns high the cycle after the first pop.
- Out of range: push (x=4,y=0) and (x=0,y=2) mid-frame → no write, error=1 and sticky; the frame completes only after 8 valid pixels.
- Address math: push (x=3,y=1,pixel=0xAB) → mem_address=7, mem_data=0xAB. With default parameters, (x=319,y=239) → mem_address=76799.
- Ignored start: pulse start during RUN → no counter clear, frame completes unchanged; start during DONE is also ignored.
